// File: rtl/rv32_pkg.sv
// Shared RV32E decode/execute definitions: opcode and branch funct3
// constants, the ALU operation enum, and the funct3-to-ALU-op helper.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASS_B = 5'd10
  } alu_op_e;

  // Base operation for OP/OP-IMM funct3; SUB/SRA are selected by the caller.
  function automatic alu_op_e f3_to_alu_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// 32-bit ALU. Ports: a, b operands; alu_op operation select; result output.
// Shifts use b[4:0]; arithmetic wraps modulo 2^32.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     alu_op,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'b0, a < b};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/rv32e_decode_exec.sv
// Combinational decode-and-execute stage of the single-cycle RV32E CPU.
// Inputs: clk, rst (sync, active-high), instr, pc, rs1_val, rs2_val.
// Outputs: rs1/rs2/rd register addresses, reg_write, wb_data, pc_next,
// take_branch, illegal (combinational) and illegal_seen (sticky, registered).
module rv32e_decode_exec
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic        reg_write,
  output logic [31:0] wb_data,
  output logic [31:0] pc_next,
  output logic        take_branch,
  output logic        illegal,
  output logic        illegal_seen
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_u, imm_j, imm_b, imm;
  logic        use_rs1, use_rs2, use_rd, sel_pc_a, sel_imm_b;
  logic        is_branch, is_jal, is_jalr, bad_enc, br_cond;
  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_result, pc_plus4;
  logic        illegal_seen_q, illegal_seen_d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[18:15];
  assign rs2    = instr[23:20];
  assign rd     = instr[10:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    alu_op    = ALU_ADD;
    imm       = imm_i;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    sel_pc_a  = 1'b0;
    sel_imm_b = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    bad_enc   = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (funct7 == 7'h00)
          alu_op = f3_to_alu_op(funct3);
        else if (funct7 == 7'h20 && funct3 == 3'b000)
          alu_op = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'b101)
          alu_op = ALU_SRA;
        else
          bad_enc = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        sel_imm_b = 1'b1;
        alu_op    = f3_to_alu_op(funct3);
        // imm[11:5] doubles as the shift-type field for SLLI/SRLI/SRAI
        if (funct3 == 3'b001 && funct7 != 7'h00)
          bad_enc = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'h20)
            alu_op = ALU_SRA;
          else if (funct7 != 7'h00)
            bad_enc = 1'b1;
        end
      end
      OPC_LUI: begin
        use_rd    = 1'b1;
        imm       = imm_u;
        sel_imm_b = 1'b1;
        alu_op    = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        use_rd    = 1'b1;
        imm       = imm_u;
        sel_pc_a  = 1'b1;
        sel_imm_b = 1'b1;
      end
      OPC_JAL: begin
        use_rd = 1'b1;
        imm    = imm_j;
        is_jal = 1'b1;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        imm       = imm_b;
        is_branch = 1'b1;
        if (funct3 == 3'b010 || funct3 == 3'b011)
          bad_enc = 1'b1;
      end
      default: bad_enc = 1'b1;
    endcase
  end

  // RV32E only has x0..x15: bit 4 of any register field in use is illegal
  assign illegal = bad_enc | (use_rs1 & instr[19]) | (use_rs2 & instr[24])
                 | (use_rd & instr[11]);

  assign alu_a = sel_pc_a ? pc : rs1_val;
  assign alu_b = sel_imm_b ? imm : rs2_val;

  rv32_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result)
  );

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (rs1_val == rs2_val);
      F3_BNE:  br_cond = (rs1_val != rs2_val);
      F3_BLT:  br_cond = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_cond = (rs1_val < rs2_val);
      F3_BGEU: br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  assign take_branch = is_branch & ~illegal & br_cond;
  assign pc_plus4    = pc + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (!illegal) begin
      if (is_jalr)
        pc_next = (rs1_val + imm) & 32'hFFFF_FFFE;
      else if (is_jal || take_branch)
        pc_next = pc + imm;
    end
  end

  assign wb_data   = (is_jal || is_jalr) ? pc_plus4 : alu_result;
  assign reg_write = use_rd & ~illegal & (rd != 4'd0);

  assign illegal_seen_d = illegal_seen_q | illegal;

  always_ff @(posedge clk) begin
    if (rst)
      illegal_seen_q <= 1'b0;
    else
      illegal_seen_q <= illegal_seen_d;
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_rv32e_decode_exec.sv
module tb_rv32e_decode_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc, rs1_val, rs2_val;
  logic [3:0]  rs1, rs2, rd;
  logic        reg_write, take_branch, illegal, illegal_seen;
  logic [31:0] wb_data, pc_next;

  always #5 clk = ~clk;

  rv32e_decode_exec dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .pc           (pc),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .reg_write    (reg_write),
    .wb_data      (wb_data),
    .pc_next      (pc_next),
    .take_branch  (take_branch),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  typedef struct {
    logic        ill;
    logic        rw;
    logic        br;
    logic        wb_valid;
    logic [31:0] wb;
    logic [31:0] pcn;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  bit   check_en = 0;
  logic exp_seen;
  exp_t ce;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (instr=%h pc=%h a=%h b=%h)",
               name, act, req, instr, pc, rs1_val, rs2_val);
    end
  endtask

  // Reference: evaluate each instruction by name from the ISA rules.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0]  f3 = i[14:12];
    logic [6:0]  f7 = i[31:25];
    logic [4:0]  sh = i[24:20];
    logic signed [31:0] sa = a;
    logic [31:0] immI = {{20{i[31]}}, i[31:20]};
    logic [31:0] immU = {i[31:12], 12'h000};
    logic [31:0] immJ = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    logic [31:0] immB = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic bad = 1'b0, cond = 1'b0, writes = 1'b0;
    e.wb = '0; e.wb_valid = 1'b0; e.pcn = p + 4; e.br = 1'b0;
    case (i[6:0])
      7'h33: begin
        bad = i[19] | i[24] | i[11]; writes = 1; e.wb_valid = 1;
        case ({f7, f3})
          {7'h00, 3'd0}: e.wb = a + b;
          {7'h20, 3'd0}: e.wb = a - b;
          {7'h00, 3'd1}: e.wb = a << b[4:0];
          {7'h00, 3'd2}: e.wb = ($signed(a) < $signed(b)) ? 1 : 0;
          {7'h00, 3'd3}: e.wb = (a < b) ? 1 : 0;
          {7'h00, 3'd4}: e.wb = a ^ b;
          {7'h00, 3'd5}: e.wb = a >> b[4:0];
          {7'h20, 3'd5}: e.wb = sa >>> b[4:0];
          {7'h00, 3'd6}: e.wb = a | b;
          {7'h00, 3'd7}: e.wb = a & b;
          default: bad = 1;
        endcase
      end
      7'h13: begin
        bad = i[19] | i[11]; writes = 1; e.wb_valid = 1;
        case (f3)
          3'd0: e.wb = a + immI;
          3'd1: begin e.wb = a << sh; if (f7 != 0) bad = 1; end
          3'd2: e.wb = ($signed(a) < $signed(immI)) ? 1 : 0;
          3'd3: e.wb = (a < immI) ? 1 : 0;
          3'd4: e.wb = a ^ immI;
          3'd5: if (f7 == 7'h00) e.wb = a >> sh;
                else if (f7 == 7'h20) e.wb = sa >>> sh;
                else bad = 1;
          3'd6: e.wb = a | immI;
          default: e.wb = a & immI;
        endcase
      end
      7'h37: begin bad = i[11]; writes = 1; e.wb_valid = 1; e.wb = immU; end
      7'h17: begin bad = i[11]; writes = 1; e.wb_valid = 1; e.wb = p + immU; end
      7'h6F: begin bad = i[11]; writes = 1; e.wb_valid = 1; e.wb = p + 4; e.pcn = p + immJ; end
      7'h67: begin
        bad = i[19] | i[11]; writes = 1; e.wb_valid = 1; e.wb = p + 4;
        e.pcn = (a + immI) & 32'hFFFF_FFFE;
      end
      7'h63: begin
        bad = i[19] | i[24];
        case (f3)
          3'd0: cond = (a == b);
          3'd1: cond = (a != b);
          3'd4: cond = ($signed(a) < $signed(b));
          3'd5: cond = ($signed(a) >= $signed(b));
          3'd6: cond = (a < b);
          3'd7: cond = (a >= b);
          default: bad = 1;
        endcase
        e.br = cond && !bad;
        if (e.br) e.pcn = p + immB;
      end
      default: bad = 1;
    endcase
    if (bad) begin
      writes = 0; e.br = 0; e.pcn = p + 4; e.wb_valid = 0;
    end
    e.ill = bad;
    e.rw  = writes && (i[10:7] != 0);
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) exp_seen <= 1'b0;
    else if (model(instr, pc, rs1_val, rs2_val).ill) exp_seen <= 1'b1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      ce = model(instr, pc, rs1_val, rs2_val);
      chk("rs1", {28'b0, rs1}, {28'b0, instr[18:15]});
      chk("rs2", {28'b0, rs2}, {28'b0, instr[23:20]});
      chk("rd", {28'b0, rd}, {28'b0, instr[10:7]});
      chk("illegal", {31'b0, illegal}, {31'b0, ce.ill});
      chk("reg_write", {31'b0, reg_write}, {31'b0, ce.rw});
      chk("take_branch", {31'b0, take_branch}, {31'b0, ce.br});
      chk("pc_next", pc_next, ce.pcn);
      if (ce.wb_valid) chk("wb_data", wb_data, ce.wb);
      chk("illegal_seen", {31'b0, illegal_seen}, {31'b0, exp_seen});
    end
  end

  task automatic apply(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic r);
    @(posedge clk);
    #1;
    instr = i; pc = p; rs1_val = a; rs2_val = b; rst = r;
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 9))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h37;
      3: r[6:0] = 7'h17;
      4: r[6:0] = 7'h6F;
      5: r[6:0] = 7'h67;
      6, 7: r[6:0] = 7'h63;
      8: r[6:0] = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h23;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) begin
      r[11] = 1'b0; r[19] = 1'b0; r[24] = 1'b0;
    end
    case ($urandom_range(0, 3))
      0, 1: r[31:25] = 7'h00;
      2: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; instr = 32'hFFF00093; pc = 32'h100; rs1_val = '0; rs2_val = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1;
    #2 chk("reset_seen", {31'b0, illegal_seen}, 32'd0);

    apply(32'hFFF00093, 32'h100, 32'h0, 32'h0, 0);
    chk("addi_rd", {28'b0, rd}, 32'd1);
    chk("addi_rw", {31'b0, reg_write}, 32'd1);
    chk("addi_wb", wb_data, 32'hFFFFFFFF);
    chk("addi_pcn", pc_next, 32'h104);

    apply(32'h402081B3, 32'h0, 32'd5, 32'd7, 0);
    chk("sub_wb", wb_data, 32'hFFFFFFFE);
    apply(32'h4020D1B3, 32'h0, 32'h80000000, 32'd4, 0);
    chk("sra_wb", wb_data, 32'hF8000000);
    apply(32'h0020B1B3, 32'h0, 32'd1, 32'hFFFFFFFF, 0);
    chk("sltu_wb", wb_data, 32'd1);

    apply(32'hFE20CCE3, 32'h20, 32'hFFFFFFFF, 32'd1, 0);
    chk("blt_taken", {31'b0, take_branch}, 32'd1);
    chk("blt_pcn", pc_next, 32'h18);
    chk("blt_rw", {31'b0, reg_write}, 32'd0);
    apply(32'hFE20ECE3, 32'h20, 32'hFFFFFFFF, 32'd1, 0);
    chk("bltu_taken", {31'b0, take_branch}, 32'd0);
    chk("bltu_pcn", pc_next, 32'h24);

    apply(32'h003100E7, 32'h40, 32'h100, 32'h0, 0);
    chk("jalr_pcn", pc_next, 32'h102);
    chk("jalr_wb", wb_data, 32'h44);
    chk("jalr_rw", {31'b0, reg_write}, 32'd1);
    apply(32'h0100006F, 32'h200, 32'h0, 32'h0, 0);
    chk("jal_x0_rw", {31'b0, reg_write}, 32'd0);
    chk("jal_x0_pcn", pc_next, 32'h210);

    apply(32'h123452B7, 32'h0, 32'h0, 32'h0, 0);
    chk("lui_wb", wb_data, 32'h12345000);
    apply(32'h00001297, 32'h10, 32'h0, 32'h0, 0);
    chk("auipc_wb", wb_data, 32'h1010);
    chk("seen_before_illegal", {31'b0, illegal_seen}, 32'd0);

    apply(32'h00002083, 32'h300, 32'h0, 32'h0, 0);
    chk("load_ill", {31'b0, illegal}, 32'd1);
    chk("load_rw", {31'b0, reg_write}, 32'd0);
    chk("load_pcn", pc_next, 32'h304);
    apply(32'hFFF00093, 32'h0, 32'h0, 32'h0, 0);
    chk("seen_set", {31'b0, illegal_seen}, 32'd1);
    apply(32'h00100813, 32'h400, 32'h0, 32'h0, 0);
    chk("rd16_ill", {31'b0, illegal}, 32'd1);
    chk("rd16_rw", {31'b0, reg_write}, 32'd0);
    chk("rd16_pcn", pc_next, 32'h404);
    apply(32'h022081B3, 32'h500, 32'd3, 32'd4, 0);
    chk("f7_ill", {31'b0, illegal}, 32'd1);
    chk("f7_rw", {31'b0, reg_write}, 32'd0);
    chk("f7_pcn", pc_next, 32'h504);
    apply(32'hFFF00093, 32'h0, 32'h0, 32'h0, 0);
    apply(32'hFFF00093, 32'h0, 32'h0, 32'h0, 0);
    chk("seen_hold", {31'b0, illegal_seen}, 32'd1);
    apply(32'h00002083, 32'h0, 32'h0, 32'h0, 1);
    apply(32'hFFF00093, 32'h0, 32'h0, 32'h0, 0);
    chk("seen_rst_priority", {31'b0, illegal_seen}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = $urandom_range(0, 40);
        default: rb = $urandom();
      endcase
      apply(rand_instr(), $urandom(), ra, rb, ($urandom_range(0, 63) == 0));
    end

    @(posedge clk);
    #1 check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32e_decode_exec.md
# rv32e_decode_exec

Combinational decode-and-execute core of the single-cycle RV32 CPU. It sits between instruction fetch and the register file. Each cycle it decodes one 32-bit instruction and supplies register-file read addresses. It computes the ALU result, resolves branches and jumps, and produces write-back data plus the next PC. A sticky illegal-instruction flag is the only state.

## Interface
- Parameters: none.
- clk  in  1  system clock (rising edge)
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction at current PC
- pc  in  32  current program counter
- rs1_val  in  32  register-file data for rs1
- rs2_val  in  32  register-file data for rs2
- rs1  out  4  source register 1 address, instr[18:15]
- rs2  out  4  source register 2 address, instr[23:20]
- rd  out  4  destination address, instr[10:7]
- reg_write  out  1  write-enable to register file
- wb_data  out  32  write-back data
- pc_next  out  32  PC for next cycle
- take_branch  out  1  conditional branch taken
- illegal  out  1  current instruction illegal (combinational)
- illegal_seen  out  1  sticky illegal flag (registered)

## Operation
- Supported opcodes are OP, OP-IMM, LUI, AUIPC, JAL, JALR and BRANCH. All other opcodes are illegal, including LOAD, STORE, FENCE and SYSTEM.
- Register fields are RV32E. The instruction is illegal if bit 4 of any used register field is set (instr[19], instr[24] or instr[11]).
- Immediates are sign-extended to 32 bits per RV32I I/U/J/B formats.
- OP: funct7 must be 0x00, or 0x20 only for SUB and SRA. Anything else is illegal.
- OP-IMM: SLLI requires imm[11:5]=0. SRLI/SRAI require imm[11:5]=0x00 or 0x20.
- Shift amounts use only the low 5 bits of the operand.
- ALU operand selection:
  - a = rs1_val, except AUIPC where a = pc.
  - b = imm for OP-IMM, LUI and AUIPC; otherwise rs2_val.
- LUI result = b. AUIPC result = pc+imm.
- The ALU supports ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and PASS_B.
- SLT/SLTU return 32-bit 0 or 1. All arithmetic wraps modulo 2^32.
- Branch funct3 mapping: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. 010 and 011 are illegal.
- take_branch = 1 only for a legal BRANCH whose condition holds on rs1_val/rs2_val.
- wb_data = pc+4 for JAL/JALR; otherwise the ALU result.
- pc_next priority:
  1. JALR: (rs1_val+imm) & ~1.
  2. JAL, or take_branch: pc+imm.
  3. Otherwise pc+4.
- reg_write = 1 for a legal OP, OP-IMM, LUI, AUIPC, JAL or JALR with rd != 0. It is 0 for branches, illegal instructions and rd = 0.
- For an illegal instruction: reg_write = 0, take_branch = 0, pc_next = pc+4. wb_data is don't-care.
- Misaligned targets are not checked.

## Timing
- All outputs except illegal_seen are purely combinational from instr, pc, rs1_val and rs2_val, with zero latency.
- illegal_seen:
  - Reset value 0.
  - Sets on the rising clk edge where illegal = 1 and rst = 0.
  - Clears only on an edge with rst = 1; rst has priority over a simultaneous illegal.
- rst does not affect combinational outputs.

## Structure
- Shared package `rv32_pkg` holds:
  - opcode constants (OP=0110011, OP_IMM=0010011, LUI=0110111, AUIPC=0010111, JAL=1101111, JALR=1100111, BRANCH=1100011);
  - branch funct3 constants;
  - the 5-bit alu_op enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
- One sub-module, `rv32_alu` (a, b, alu_op → result), is instantiated once. Decode, branch compare and next-PC logic stay in this block.

## Test plan
- ADDI x1, x0, -1 (0xFFF00093): rd=1, reg_write=1, wb_data=0xFFFFFFFF, pc_next=pc+4.
- SUB x3, x1, x2 with rs1_val=5, rs2_val=7: wb_data=0xFFFFFFFE. SRA of 0x80000000 by 4 gives 0xF8000000. SLTU of 1 vs 0xFFFFFFFF gives 1.
- BLT with rs1_val=0xFFFFFFFF and rs2_val=1, imm=-8, pc=0x20: take_branch=1, pc_next=0x18, reg_write=0. The same instruction as BLTU gives take_branch=0, pc_next=0x24.
- JALR x1, 3(x2) with rs1_val=0x100, pc=0x40: pc_next=0x102, wb_data=0x44, reg_write=1. JAL with rd=0: reg_write=0, pc_next=pc+imm.
- LUI x5, 0x12345: wb_data=0x12345000. AUIPC with imm=0x1000 at pc=0x10: wb_data=0x1010.
- Illegal cases: LOAD opcode, rd field=16 and OP with funct7=0x01 each give illegal=1, reg_write=0, pc_next=pc+4. illegal_seen rises after the next edge and holds through legal instructions until an rst edge clears it; rst together with an illegal instruction still leaves 0.
